bin_frame_serializer: RTL and testbench
=======================================

Name: bin_frame_serializer

Overview:
- Consumer end of the channelizer output bus. Captures each averaged-bin frame (valid strobe plus packed N_out-bit words) and streams it out one N_out-bit word per beat on an AXI-Stream-style master.
- Prepends a frame sequence header to every frame.
- Sits between the channelizer and the Ethernet TX packet builder.
- Double-buffers frames so a new frame can arrive while the previous one is draining; counts frames dropped on overflow.

Parameters:
- N, 16, width of one averaged bin sample
- N_out, 8, output word width; N must be a multiple of N_out
- BINS, 4, bins per frame
- SEQ_W, 16, sequence header width; must be a multiple of N_out
- Derived: WORDS = BINS*N/N_out (8); HDR_WORDS = SEQ_W/N_out (2); FRAME_LEN = HDR_WORDS+WORDS (10)

Ports:
- clk  in  1  single clock
- arest_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle
- in_data  in  [WORDS-1:0][N_out-1:0]  packed frame; word k is in_data[k]
- m_tdata  out  N_out  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  high on the final payload word of a frame
- overflow  out  1  one-cycle pulse when a frame is dropped
- drop_count  out  16  saturating count of dropped frames
- seq_num  out  SEQ_W  sequence number of the next frame to be emitted

Behaviour:
- Reset is asynchronous. All of the following are 0 during and after reset: m_tvalid, m_tlast, m_tdata, overflow, drop_count, seq_num, state, both buffer-full flags.
- Reset mid-frame abandons the frame. There is no partial-frame completion after reset.
- Buffers:
  - ACTIVE holds the frame currently being sent.
  - PENDING holds one queued frame.
  - Each buffer has a full flag.
- Capture on in_valid:
  - If ACTIVE is empty, or is being freed this cycle (tlast handshake) with PENDING empty, load ACTIVE.
  - Else if PENDING is empty, or is being promoted this cycle, load PENDING.
  - Else drop the frame: overflow=1 for one cycle and drop_count += 1, saturating at 16'hFFFF. The existing buffers are untouched.
- Handshake:
  - A beat transfers when m_tvalid && m_tready.
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
  - m_tvalid never deasserts without a transfer, except on reset.
- FSM:
  - IDLE: m_tvalid=0. When ACTIVE becomes full, go to HDR with m_tvalid=1 on the next cycle. Latency is in_valid at cycle t, first header word valid at t+1.
  - HDR: emit seq_num MSB-first, N_out bits per beat, for HDR_WORDS beats. The header value is latched when the frame enters ACTIVE. After the last header beat, go to PAYLOAD.
  - PAYLOAD: emit in_data[0] through in_data[WORDS-1] in order, with m_tlast=1 on word WORDS-1.
- At the tlast handshake:
  - seq_num increments, wrapping modulo 2^SEQ_W.
  - If PENDING is full, it is promoted to ACTIVE in the same cycle and the FSM goes to HDR with m_tvalid held 1, so there is no bubble.
  - Otherwise ACTIVE is cleared and the FSM goes to IDLE with m_tvalid=0.
- The word index counter is $clog2(FRAME_LEN) bits and resets to 0 on every frame start.
- Simultaneous tlast handshake, in_valid and PENDING full: PENDING is promoted and the new frame loads PENDING. No drop occurs.
- Continuous m_tready=1 with back-to-back frames gives exactly FRAME_LEN beats per frame and no idle cycles between frames.

Decomposition:
- Shared package bin_stream_pkg:
  - localparams WORDS, HDR_WORDS, FRAME_LEN
  - state enum typedef {IDLE, HDR, PAYLOAD}
  - frame typedef logic [WORDS-1:0][N_out-1:0]
- One sub-module, bin_frame_buf: two-entry ping-pong holding buffer.
  - Inputs: load strobe, release strobe.
  - Outputs: active frame, full flags, drop indication.
- The top level holds the FSM, index counter, sequence counter and drop counter.

Test Plan (defaults: WORDS=8, FRAME_LEN=10):
- Single frame, m_tready=1. Reset, then in_valid with in_data words 0x10..0x17 -> m_tvalid rises the next cycle. Data 0x00,0x00,0x10..0x17. m_tlast on beat 10 only. Then m_tvalid=0 and seq_num=1.
- Backpressure: toggle m_tready 1/0 every cycle -> m_tdata and m_tlast hold stable while stalled. The full 10-word sequence arrives in order with no loss or duplication.
- Back-to-back: three frames, spaced so each arrives while the prior one is draining, with m_tready=1 -> 30 contiguous beats. Headers read 0x0000, 0x0001, 0x0002. drop_count=0.
- Overflow: m_tready=0, then in_valid three times -> third frame dropped, overflow pulses once, drop_count=1. Releasing m_tready yields frames 1 and 2 only.
- Simultaneous: in_valid on the same cycle as the tlast handshake with PENDING full -> no drop, three frames emitted.
- Reset mid-frame: assert arest_n=0 at beat 4 -> m_tvalid=0 immediately (asynchronous). After release, the next frame starts with header 0x0000 and drop_count=0.
- Wrap: preload seq_num to 0xFFFF via a hierarchical force -> the header reads 0xFF,0xFF and the next header reads 0x00,0x00.

Source files
------------

// File: rtl/bin_stream_pkg.sv
// Shared types and sizes for the averaged-bin frame serializer.
// Frame geometry, FSM state encoding and buffer word types.
package bin_stream_pkg;

  localparam int N         = 16;
  localparam int N_OUT     = 8;
  localparam int BINS      = 4;
  localparam int SEQ_W     = 16;
  localparam int WORDS     = BINS * N / N_OUT;
  localparam int HDR_WORDS = SEQ_W / N_OUT;
  localparam int FRAME_LEN = HDR_WORDS + WORDS;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int WIDX_W    = $clog2(WORDS);
  localparam int HIDX_W    =
    (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_e;

  typedef logic [WORDS-1:0][N_OUT-1:0] frame_t;
  typedef logic [HDR_WORDS-1:0][N_OUT-1:0] hdr_t;

endpackage

// File: rtl/bin_frame_buf.sv
// Two-entry ping-pong holding buffer: ACTIVE drains, PENDING queues.
// Ports: load_i/load_data_i capture, free_i releases ACTIVE; start_o
// flags a frame entering ACTIVE, drop_o a frame that found no room.
module bin_frame_buf
  import bin_stream_pkg::*;
(
  input  logic   clk,
  input  logic   arest_n,
  input  logic   load_i,
  input  frame_t load_data_i,
  input  logic   free_i,
  output frame_t act_data_o,
  output logic   act_full_o,
  output logic   pnd_full_o,
  output logic   start_o,
  output logic   drop_o
);

  frame_t act_q, act_d;
  frame_t pnd_q, pnd_d;
  logic   act_full_q, act_full_d;
  logic   pnd_full_q, pnd_full_d;
  logic   promote, ld_act, ld_pnd;

  always_comb begin
    promote = free_i && pnd_full_q;
    ld_act  = load_i &&
              (!act_full_q || (free_i && !pnd_full_q));
    ld_pnd  = load_i && !ld_act &&
              (!pnd_full_q || promote);
    drop_o  = load_i && !ld_act && !ld_pnd;
    start_o = ld_act || promote;

    act_d      = act_q;
    act_full_d = act_full_q;
    pnd_d      = pnd_q;
    pnd_full_d = pnd_full_q;

    if (ld_act) begin
      act_d      = load_data_i;
      act_full_d = 1'b1;
    end else if (promote) begin
      act_d      = pnd_q;
      act_full_d = 1'b1;
    end else if (free_i) begin
      act_full_d = 1'b0;
    end

    // A promote and a fresh load may coincide: PENDING refills.
    if (ld_pnd) begin
      pnd_d      = load_data_i;
      pnd_full_d = 1'b1;
    end else if (promote) begin
      pnd_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      act_q      <= '0;
      pnd_q      <= '0;
      act_full_q <= 1'b0;
      pnd_full_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      pnd_q      <= pnd_d;
      act_full_q <= act_full_d;
      pnd_full_q <= pnd_full_d;
    end
  end

  assign act_data_o = act_q;
  assign act_full_o = act_full_q;
  assign pnd_full_o = pnd_full_q;

endmodule

// File: rtl/bin_frame_serializer.sv
// Streams captured bin frames as header+payload words on a master.
// Ports: in_valid/in_data capture, m_t* stream out, overflow/drop_count
// report dropped frames, seq_num is the next frame's sequence number.
module bin_frame_serializer
  import bin_stream_pkg::*;
(
  input  logic             clk,
  input  logic             arest_n,
  input  logic             in_valid,
  input  frame_t           in_data,
  output logic [N_OUT-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic [SEQ_W-1:0] seq_num
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  hdr_t               hdr_q, hdr_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;

  frame_t             act_data;
  logic               act_full, pnd_full;
  logic               start, drop;
  logic               fire, free;
  logic [IDX_W-1:0]   off;
  logic [WIDX_W-1:0]  widx;
  logic [HIDX_W-1:0]  hidx;

  bin_frame_buf u_buf (
    .clk        (clk),
    .arest_n    (arest_n),
    .load_i     (in_valid),
    .load_data_i(in_data),
    .free_i     (free),
    .act_data_o (act_data),
    .act_full_o (act_full),
    .pnd_full_o (pnd_full),
    .start_o    (start),
    .drop_o     (drop)
  );

  // A frame sits in ACTIVE exactly while it is being offered.
  assign m_tvalid = act_full;
  assign m_tlast  = (state_q == PAYLOAD) &&
                    (idx_q == IDX_W'(FRAME_LEN - 1));
  assign fire     = m_tvalid && m_tready;
  assign free     = fire && m_tlast;

  // Header goes MSB word first.
  assign hidx = HIDX_W'(IDX_W'(HDR_WORDS - 1) - idx_q);
  assign off  = idx_q - IDX_W'(HDR_WORDS);
  assign widx = WIDX_W'(off);

  always_comb begin
    m_tdata = '0;
    unique case (state_q)
      HDR:     m_tdata = hdr_q[hidx];
      PAYLOAD: m_tdata = act_data[widx];
      default: m_tdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    hdr_d      = hdr_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = drop;

    if (free) seq_d = seq_q + 1'b1;
    // A frame entering ACTIVE at a tlast takes the bumped number.
    if (start) hdr_d = seq_d;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          idx_d   = '0;
        end
      end
      HDR, PAYLOAD: begin
        if (fire) begin
          if (m_tlast) begin
            state_d = (start || pnd_full) ? HDR : IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_d >= IDX_W'(HDR_WORDS))
                      ? PAYLOAD : HDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      hdr_q      <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      hdr_q      <= hdr_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_cnt_q;
  assign seq_num    = seq_q;

endmodule

// File: tb/tb_bin_frame_serializer.sv
// Directed plus random bench for bin_frame_serializer.
// Model: a beat queue filled from accepted frames, capacity two frames.
module tb_bin_frame_serializer;
  import bin_stream_pkg::*;

  logic             clk = 1'b0;
  logic             arest_n;
  logic             in_valid;
  frame_t           in_data;
  logic [N_OUT-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             overflow;
  logic [15:0]      drop_count;
  logic [SEQ_W-1:0] seq_num;

  always #5 clk = ~clk;

  bin_frame_serializer dut (
    .clk       (clk),
    .arest_n   (arest_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .overflow  (overflow),
    .drop_count(drop_count),
    .seq_num   (seq_num)
  );

  typedef struct packed {
    logic [N_OUT-1:0] d;
    logic             l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks;
  int          failures;
  logic [15:0] seq_base;
  logic [15:0] done_cnt;
  logic [15:0] acc_cnt;
  logic [15:0] exp_drops;
  logic        exp_ovf;
  frame_t      zf;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int frames_q();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].l) n++;
    return n;
  endfunction

  function automatic frame_t mk(logic [7:0] base);
    frame_t f;
    for (int k = 0; k < WORDS; k++)
      f[k] = N_OUT'(base + 8'(k));
    return f;
  endfunction

  function automatic frame_t rnd();
    frame_t f;
    for (int k = 0; k < WORDS; k++)
      f[k] = N_OUT'($urandom);
    return f;
  endfunction

  task automatic push_frame(frame_t f);
    logic [SEQ_W-1:0] h;
    beat_t b;
    h = seq_base + acc_cnt;
    acc_cnt++;
    for (int i = 0; i < HDR_WORDS; i++) begin
      b.d = N_OUT'(h >> (SEQ_W - N_OUT * (i + 1)));
      b.l = 1'b0;
      exp_q.push_back(b);
    end
    for (int k = 0; k < WORDS; k++) begin
      b.d = f[k];
      b.l = (k == WORDS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic step(bit iv, frame_t f, bit rdy);
    logic [15:0] es;
    bit tl;
    @(negedge clk);
    in_valid = iv;
    in_data  = f;
    m_tready = rdy;
    es = seq_base + done_cnt;
    chk("tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("drop_count", 32'(drop_count), 32'(exp_drops));
    chk("seq_num", 32'(seq_num), 32'(es));
    tl = 1'b0;
    if (exp_q.size() != 0 && m_tvalid) begin
      chk("tdata", 32'(m_tdata), 32'(exp_q[0].d));
      chk("tlast", 32'(m_tlast), 32'(exp_q[0].l));
      if (rdy) begin
        tl = exp_q[0].l;
        void'(exp_q.pop_front());
        if (tl) done_cnt++;
      end
    end
    exp_ovf = 1'b0;
    if (iv) begin
      if (frames_q() < 2) push_frame(f);
      else begin
        exp_ovf = 1'b1;
        if (exp_drops != 16'hFFFF) exp_drops++;
      end
    end
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, zf, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    arest_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_seq_num", 32'(seq_num), 32'd0);
    exp_q.delete();
    seq_base  = '0;
    done_cnt  = '0;
    acc_cnt   = '0;
    exp_drops = '0;
    exp_ovf   = 1'b0;
    @(negedge clk);
    arest_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    zf       = '0;
    in_data  = '0;
    in_valid = 1'b0;
    m_tready = 1'b0;
    arest_n  = 1'b1;
    exp_q.delete();

    // single frame
    do_reset();
    step(1'b1, mk(8'h10), 1'b1);
    idle(14, 1'b1);
    chk("single_seq", 32'(seq_num), 32'd1);

    // backpressure, ready toggling
    do_reset();
    step(1'b1, mk(8'h20), 1'b1);
    for (int i = 0; i < 24; i++)
      step(1'b0, zf, (i % 2) == 1);
    idle(4, 1'b1);

    // back-to-back, each arriving while the prior drains
    do_reset();
    step(1'b1, mk(8'h30), 1'b1);
    idle(3, 1'b1);
    step(1'b1, mk(8'h40), 1'b1);
    idle(6, 1'b1);
    step(1'b1, mk(8'h50), 1'b1);
    idle(26, 1'b1);
    chk("b2b_drops", 32'(drop_count), 32'd0);

    // overflow with the sink stalled
    do_reset();
    step(1'b1, mk(8'h60), 1'b0);
    step(1'b1, mk(8'h70), 1'b0);
    step(1'b1, mk(8'h80), 1'b0);
    idle(3, 1'b0);
    idle(24, 1'b1);
    chk("ovf_drops", 32'(drop_count), 32'd1);

    // new frame on the tlast handshake with PENDING full
    do_reset();
    step(1'b1, mk(8'h90), 1'b1);
    step(1'b1, mk(8'hA0), 1'b1);
    idle(8, 1'b1);
    step(1'b1, mk(8'hB0), 1'b1);
    idle(24, 1'b1);
    chk("sim_drops", 32'(drop_count), 32'd0);
    chk("sim_seq", 32'(seq_num), 32'd3);

    // reset in the middle of a frame
    do_reset();
    step(1'b1, mk(8'hC0), 1'b1);
    idle(4, 1'b1);
    do_reset();
    step(1'b1, mk(8'hD0), 1'b1);
    idle(12, 1'b1);

    // sequence wrap
    do_reset();
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    seq_base = 16'hFFFF;
    step(1'b1, mk(8'hE0), 1'b1);
    idle(2, 1'b1);
    release dut.seq_q;
    idle(3, 1'b1);
    step(1'b1, mk(8'hF0), 1'b1);
    idle(16, 1'b1);

    // random traffic and backpressure
    do_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom % 5) == 0, rnd(),
           ($urandom % 4) != 0);
    idle(40, 1'b1);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
